// File: rtl/synchronous_modn_up_counter.sv
// ---------------------------------------------------------------------------
// synchronous_modn_up_counter
//
// Purpose:
//   Synchronous modulo-(mod_max+1) up counter. It is built as a chain of
//   T-stages that all share one clock. Stage i toggles when the count is
//   enabled and every lower bit is 1. A synchronous terminal-count clear
//   overrides the whole chain, and a parallel load overrides everything.
//
// Parameters:
//   WIDTH    counter width in bits (legal 2..16, default 4)
//
// Ports:
//   clk      single clock; all state updates on the rising edge
//   rst_n    asynchronous active-low reset (q = 0, wrap = 0)
//   t        count enable; 1 = advance on this edge
//   load     synchronous parallel load strobe (highest priority)
//   d        parallel load value
//   mod_max  terminal count; the sequence is 0..mod_max
//   q        registered count value
//   q_bar    bitwise complement of q
//   tc       combinational terminal-count flag, t & (q >= mod_max)
//   wrap     registered one-cycle pulse after a counting return to 0
// ---------------------------------------------------------------------------
module synchronous_modn_up_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             t,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] mod_max,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
    $error("synchronous_modn_up_counter: WIDTH must be in 2..16");
  end

  logic [WIDTH-1:0] toggle_en;
  logic             at_terminal;

  // Toggle-enable chain. Stage i toggles when t is set and q[i-1:0] is all
  // ones. Each stage is built from the stage below it, so the chain stays
  // a single AND per bit.
  // NOTE: every signal written in always_comb receives a value on every path
  // (here bit 0 is assigned first and the loop covers the rest). If any path
  // left a signal unassigned, the tool would infer a latch.
  always_comb begin
    toggle_en[0] = t;
    for (int i = 1; i < WIDTH; i++) begin
      toggle_en[i] = toggle_en[i-1] & q[i-1];
    end
  end

  // Unsigned compare. The >= form catches a value loaded above mod_max, so
  // the next count clears to 0 instead of running up to all-ones.
  assign at_terminal = (q >= mod_max);
  assign tc          = t & at_terminal;

  // q_bar comes from q, so it can never differ from ~q. That holds during
  // reset as well.
  assign q_bar = ~q;

  // Priority: load > terminal clear > T-stage toggle. When t is 0 the toggle
  // enables are all 0, so q holds.
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values from before the edge. This keeps the edge free of
  // ordering races between always blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= d;
      wrap <= 1'b0;
    end else if (tc) begin
      q    <= '0;
      wrap <= 1'b1;
    end else begin
      q    <= q ^ toggle_en;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_synchronous_modn_up_counter.sv
// ---------------------------------------------------------------------------
// tb_synchronous_modn_up_counter
//
// Self-checking bench for synchronous_modn_up_counter with WIDTH = 4.
// A behavioural model computes the expected count with plain integer
// arithmetic. A compare process checks q, q_bar, wrap and tc against the
// model on every falling edge. Directed scenarios pin the model with
// hand-written literal sequences. A randomized phase then mixes load,
// enable, mod_max changes and asynchronous reset pulses.
// ---------------------------------------------------------------------------
module tb_synchronous_modn_up_counter;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         t;
  logic         load;
  logic [W-1:0] d;
  logic [W-1:0] mod_max;
  logic [W-1:0] q;
  logic [W-1:0] q_bar;
  logic         tc;
  logic         wrap;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state.
  int m_q    = 0;
  int m_wrap = 0;

  synchronous_modn_up_counter #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .t       (t),
    .load    (load),
    .d       (d),
    .mod_max (mod_max),
    .q       (q),
    .q_bar   (q_bar),
    .tc      (tc),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: the rule table applied to an integer count in 0..15.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q    = 0;
      m_wrap = 0;
    end else if (load) begin
      m_q    = int'(d);
      m_wrap = 0;
    end else if (t) begin
      if (m_q >= int'(mod_max)) begin
        m_q    = 0;
        m_wrap = 1;
      end else begin
        m_q    = (m_q + 1) % (1 << W);
        m_wrap = 0;
      end
    end else begin
      m_wrap = 0;
    end
  end

  // Continuous compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    check("model_q",     int'(q),     m_q);
    check("model_q_bar", int'(q_bar), (~m_q) & ((1 << W) - 1));
    check("model_wrap",  int'(wrap),  m_wrap);
    check("model_tc",    int'(tc),    (t && (m_q >= int'(mod_max))) ? 1 : 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    t     = 1'b0;
    load  = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  localparam int Q29 [14] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0, 1, 2};
  localparam int W29 [14] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};

  initial begin
    // Reset state. While rst_n is low, tc still follows t and mod_max, with
    // q held at 0.
    rst_n   = 1'b0;
    t       = 1'b1;
    load    = 1'b0;
    d       = '0;
    mod_max = '0;
    #1;
    check("reset_q",     int'(q),     0);
    check("reset_q_bar", int'(q_bar), 15);
    check("reset_wrap",  int'(wrap),  0);
    check("reset_tc_t1", int'(tc),    1);
    t = 1'b0;
    #1;
    check("reset_tc_t0", int'(tc), 0);
    // Load and t are ignored across an edge while reset is held.
    load = 1'b1;
    d    = 4'd9;
    t    = 1'b1;
    tick();
    check("reset_ignores_load", int'(q), 0);
    do_reset();

    // Modulo-6 sequence.
    mod_max = 4'd5;
    t       = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("mod6_q",    int'(q),    Q29[i]);
      check("mod6_wrap", int'(wrap), W29[i]);
      check("mod6_tc",   int'(tc),   (Q29[i] == 5) ? 1 : 0);
      check("mod6_qbar", int'(q_bar), 15 - Q29[i]);
    end

    // Full binary sequence, with a single wrap after F -> 0.
    do_reset();
    mod_max = 4'hF;
    t       = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      check("full_q",    int'(q),    (i + 1) % 16);
      check("full_wrap", int'(wrap), (i == 15) ? 1 : 0);
    end

    // Load above mod_max; the next count clears to 0.
    do_reset();
    mod_max = 4'd5;
    load    = 1'b1;
    d       = 4'd9;
    tick();
    check("above_load_q", int'(q), 9);
    load = 1'b0;
    t    = 1'b1;
    #1;
    check("above_tc", int'(tc), 1);
    tick();
    check("above_clear_q",    int'(q),    0);
    check("above_clear_wrap", int'(wrap), 1);
    tick();
    check("above_next_q",    int'(q),    1);
    check("above_next_wrap", int'(wrap), 0);

    // Load wins over t on the same edge, then the count holds.
    do_reset();
    mod_max = 4'hF;
    t       = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("prio_pre_q", int'(q), 3);
    load = 1'b1;
    d    = 4'd7;
    tick();
    check("prio_q",    int'(q),    7);
    check("prio_wrap", int'(wrap), 0);
    load = 1'b0;
    t    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_q", int'(q), 7);
    end

    // Asynchronous reset between edges, in the middle of a count.
    do_reset();
    mod_max = 4'hF;
    t       = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("async_pre_q", int'(q), 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_q",     int'(q),     0);
    check("async_q_bar", int'(q_bar), 15);
    check("async_wrap",  int'(wrap),  0);
    #1;
    rst_n = 1'b1;
    tick();
    check("async_release_q", int'(q), 1);

    // mod_max = 0: q stays 0, wrap and tc stay high.
    do_reset();
    mod_max = '0;
    t       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mod1_q",    int'(q),    0);
      check("mod1_wrap", int'(wrap), 1);
      check("mod1_tc",   int'(tc),   1);
    end

    // Randomized phase. Here the falling-edge compare against the model
    // does all the checking.
    do_reset();
    mod_max = 4'd9;
    for (int i = 0; i < 1500; i++) begin
      load = ($urandom_range(0, 9) == 0);
      t    = ($urandom_range(0, 9) < 7);
      d    = 4'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0:       mod_max = '0;
          1:       mod_max = 4'hF;
          default: mod_max = 4'($urandom);
        endcase
      end
      if ($urandom_range(0, 99) == 0) begin
        #1;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      tick();
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
